// File: rtl/spatz_vrf_banked_pkg.sv
// Shared types and defaults for the banked Spatz vector register file.
package spatz_vrf_banked_pkg;

    localparam int unsigned NrVrfBanks    = 4;
    localparam int unsigned NrVrfWords    = 256;
    localparam int unsigned VregDataWidth = 64;

    typedef logic [VregDataWidth-1:0]                  vreg_data_t;
    typedef logic [VregDataWidth/8-1:0]                vreg_be_t;
    typedef logic [$clog2(NrVrfBanks)-1:0]             vrf_bank_idx_t;
    typedef logic [$clog2(NrVrfWords/NrVrfBanks)-1:0]  vrf_row_t;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spatz_vrf_bank.sv
// One 1R1W register-file bank with byte-enable writes, read-first registered output
// and per-bank read/write arbiters (round-robin when SPATZ_VRF_RR_ARB_EN is defined).
module spatz_vrf_bank
    import spatz_vrf_banked_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = $bits(vreg_data_t),
    parameter int unsigned NR_ROWS        = NrVrfWords / NrVrfBanks,
    parameter int unsigned NR_READ_PORTS  = 3,
    parameter int unsigned NR_WRITE_PORTS = 2,
    parameter int unsigned ROW_WIDTH      = clog2_min1(NR_ROWS)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NR_READ_PORTS-1:0]             rreq,
    input  logic [NR_READ_PORTS*ROW_WIDTH-1:0]   rrow,
    input  logic [NR_WRITE_PORTS-1:0]            wreq,
    input  logic [NR_WRITE_PORTS*ROW_WIDTH-1:0]  wrow,
    input  logic [NR_WRITE_PORTS*DATA_WIDTH-1:0] wdata,
    input  logic [NR_WRITE_PORTS*DATA_WIDTH/8-1:0] wbe,
    output logic [NR_WRITE_PORTS-1:0]            wgnt,
    output logic [NR_READ_PORTS-1:0]             rvalid,
    output logic [DATA_WIDTH-1:0]                rdata
);

    localparam int unsigned RPTR_W = clog2_min1(NR_READ_PORTS);
    localparam int unsigned WPTR_W = clog2_min1(NR_WRITE_PORTS);
    localparam int unsigned BE_W   = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0]    mem [NR_ROWS];
    logic [NR_READ_PORTS-1:0] rgnt;
    logic                     rany, wany;
    logic [ROW_WIDTH-1:0]     rsel_row, wsel_row;
    logic [DATA_WIDTH-1:0]    wsel_data;
    logic [BE_W-1:0]          wsel_be;
    logic [RPTR_W-1:0]        rstart;
    logic [WPTR_W-1:0]        wstart;
    int unsigned              ridx, widx;

`ifdef SPATZ_VRF_RR_ARB_EN
    logic [RPTR_W-1:0] rptr_q, rptr_d;
    logic [WPTR_W-1:0] wptr_q, wptr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr_q <= '0;
            wptr_q <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
        end
    end

    assign rstart = rptr_q;
    assign wstart = wptr_q;
`else
    assign rstart = '0;
    assign wstart = '0;
`endif

    // Both arbiters scan from their start index; fixed priority simply starts at port 0.
    always_comb begin
        rgnt     = '0;
        rany     = 1'b0;
        rsel_row = '0;
        ridx     = 0;
`ifdef SPATZ_VRF_RR_ARB_EN
        rptr_d   = rptr_q;
`endif
        for (int unsigned i = 0; i < NR_READ_PORTS; i++) begin
            ridx = (32'(rstart) + i) % NR_READ_PORTS;
            if (!rany && rreq[ridx]) begin
                rany       = 1'b1;
                rgnt[ridx] = 1'b1;
                rsel_row   = rrow[ridx*ROW_WIDTH +: ROW_WIDTH];
`ifdef SPATZ_VRF_RR_ARB_EN
                rptr_d     = RPTR_W'((ridx + 1) % NR_READ_PORTS);
`endif
            end
        end
    end

    always_comb begin
        wgnt      = '0;
        wany      = 1'b0;
        wsel_row  = '0;
        wsel_data = '0;
        wsel_be   = '0;
        widx      = 0;
`ifdef SPATZ_VRF_RR_ARB_EN
        wptr_d    = wptr_q;
`endif
        for (int unsigned i = 0; i < NR_WRITE_PORTS; i++) begin
            widx = (32'(wstart) + i) % NR_WRITE_PORTS;
            if (!wany && wreq[widx]) begin
                wany       = 1'b1;
                wgnt[widx] = 1'b1;
                wsel_row   = wrow[widx*ROW_WIDTH +: ROW_WIDTH];
                wsel_data  = wdata[widx*DATA_WIDTH +: DATA_WIDTH];
                wsel_be    = wbe[widx*BE_W +: BE_W];
`ifdef SPATZ_VRF_RR_ARB_EN
                wptr_d     = WPTR_W'((widx + 1) % NR_WRITE_PORTS);
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rvalid <= '0;
        else     rvalid <= rgnt;
    end

    // Sampled before the same-edge write lands, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (rany) rdata <= mem[rsel_row];
    end

    always_ff @(posedge clk) begin
        if (wany && !rst) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (wsel_be[b]) mem[wsel_row][b*8 +: 8] <= wsel_data[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/spatz_vrf_banked.sv
// Banked multi-ported Spatz VRF: routes requester ports onto NR_BANKS interleaved banks.
// Optional round-robin bank arbitration: define SPATZ_VRF_RR_ARB_EN.
module spatz_vrf_banked
    import spatz_vrf_banked_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = $bits(vreg_data_t),
    parameter int unsigned NR_WORDS       = NrVrfWords,
    parameter int unsigned NR_BANKS       = NrVrfBanks,
    parameter int unsigned NR_READ_PORTS  = 3,
    parameter int unsigned NR_WRITE_PORTS = 2,
    parameter int unsigned ADDR_WIDTH     = $clog2(NR_WORDS)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NR_WRITE_PORTS*ADDR_WIDTH-1:0]   waddr_i,
    input  logic [NR_WRITE_PORTS*DATA_WIDTH-1:0]   wdata_i,
    input  logic [NR_WRITE_PORTS*DATA_WIDTH/8-1:0] wbe_i,
    input  logic [NR_WRITE_PORTS-1:0]              we_i,
    output logic [NR_WRITE_PORTS-1:0]              wvalid_o,
    input  logic [NR_READ_PORTS*ADDR_WIDTH-1:0]    raddr_i,
    input  logic [NR_READ_PORTS-1:0]               re_i,
    output logic [NR_READ_PORTS*DATA_WIDTH-1:0]    rdata_o,
    output logic [NR_READ_PORTS-1:0]               rvalid_o
);

    localparam int unsigned BANK_SHIFT = $clog2(NR_BANKS);
    localparam int unsigned BANK_W     = clog2_min1(NR_BANKS);
    localparam int unsigned NR_ROWS    = NR_WORDS / NR_BANKS;
    localparam int unsigned ROW_WIDTH  = clog2_min1(NR_ROWS);

    logic [NR_READ_PORTS*ROW_WIDTH-1:0]  rrow;
    logic [NR_WRITE_PORTS*ROW_WIDTH-1:0] wrow;
    logic [NR_READ_PORTS-1:0]            bank_rreq   [NR_BANKS];
    logic [NR_READ_PORTS-1:0]            bank_rvalid [NR_BANKS];
    logic [NR_WRITE_PORTS-1:0]           bank_wreq   [NR_BANKS];
    logic [NR_WRITE_PORTS-1:0]           bank_wgnt   [NR_BANKS];
    logic [DATA_WIDTH-1:0]               bank_rdata  [NR_BANKS];
    logic [NR_READ_PORTS*DATA_WIDTH-1:0] rdata_q;
    logic [ADDR_WIDTH-1:0]               raddr, waddr;
    logic [BANK_W-1:0]                   rbank, wbank;

    // Rows are shared by all banks; each bank only sees requests masked to it.
    always_comb begin
        rrow  = '0;
        wrow  = '0;
        raddr = '0;
        waddr = '0;
        rbank = '0;
        wbank = '0;
        for (int unsigned b = 0; b < NR_BANKS; b++) begin
            bank_rreq[b] = '0;
            bank_wreq[b] = '0;
        end
        for (int unsigned p = 0; p < NR_READ_PORTS; p++) begin
            raddr = raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
            rbank = (NR_BANKS > 1) ? BANK_W'(raddr) : '0;
            rrow[p*ROW_WIDTH +: ROW_WIDTH] = ROW_WIDTH'(raddr >> BANK_SHIFT);
            bank_rreq[rbank][p] = re_i[p];
        end
        for (int unsigned p = 0; p < NR_WRITE_PORTS; p++) begin
            waddr = waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
            wbank = (NR_BANKS > 1) ? BANK_W'(waddr) : '0;
            wrow[p*ROW_WIDTH +: ROW_WIDTH] = ROW_WIDTH'(waddr >> BANK_SHIFT);
            bank_wreq[wbank][p] = we_i[p];
        end
    end

    for (genvar b = 0; b < NR_BANKS; b++) begin : g_bank
        spatz_vrf_bank #(
            .DATA_WIDTH     (DATA_WIDTH),
            .NR_ROWS        (NR_ROWS),
            .NR_READ_PORTS  (NR_READ_PORTS),
            .NR_WRITE_PORTS (NR_WRITE_PORTS),
            .ROW_WIDTH      (ROW_WIDTH)
        ) i_bank (
            .clk    (clk_i),
            .rst    (rst_i),
            .rreq   (bank_rreq[b]),
            .rrow   (rrow),
            .wreq   (bank_wreq[b]),
            .wrow   (wrow),
            .wdata  (wdata_i),
            .wbe    (wbe_i),
            .wgnt   (bank_wgnt[b]),
            .rvalid (bank_rvalid[b]),
            .rdata  (bank_rdata[b])
        );
    end

    // A port gets data from at most one bank per cycle; otherwise it holds its last value.
    always_comb begin
        wvalid_o = '0;
        rvalid_o = '0;
        rdata_o  = rdata_q;
        for (int unsigned b = 0; b < NR_BANKS; b++) begin
            wvalid_o = wvalid_o | bank_wgnt[b];
            rvalid_o = rvalid_o | bank_rvalid[b];
            for (int unsigned p = 0; p < NR_READ_PORTS; p++) begin
                if (bank_rvalid[b][p]) rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = bank_rdata[b];
            end
        end
        if (rst_i) wvalid_o = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rdata_q <= '0;
        else       rdata_q <= rdata_o;
    end

endmodule

// File: tb/tb_spatz_vrf_banked.sv
// Directed self-checking bench for spatz_vrf_banked (default 64b x 256 words, 4 banks, 3R/2W).
module tb_spatz_vrf_banked;

    localparam int unsigned DW  = 64;
    localparam int unsigned AW  = 8;
    localparam int unsigned NRP = 3;
    localparam int unsigned NWP = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NWP*AW-1:0]  waddr;
    logic [NWP*DW-1:0]  wdata;
    logic [NWP*8-1:0]   wbe;
    logic [NWP-1:0]     we;
    logic [NWP-1:0]     wvalid;
    logic [NRP*AW-1:0]  raddr;
    logic [NRP-1:0]     re;
    logic [NRP*DW-1:0]  rdata;
    logic [NRP-1:0]     rvalid;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [1:0]  rr_exp [4];

    always #5 clk = ~clk;

    spatz_vrf_banked #(
        .DATA_WIDTH     (DW),
        .NR_WORDS       (256),
        .NR_BANKS       (4),
        .NR_READ_PORTS  (NRP),
        .NR_WRITE_PORTS (NWP)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .waddr_i  (waddr),
        .wdata_i  (wdata),
        .wbe_i    (wbe),
        .we_i     (we),
        .wvalid_o (wvalid),
        .raddr_i  (raddr),
        .re_i     (re),
        .rdata_o  (rdata),
        .rvalid_o (rvalid)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_write(input int unsigned p, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [7:0] be);
        waddr[p*AW +: AW] = a;
        wdata[p*DW +: DW] = d;
        wbe[p*8 +: 8]     = be;
        we[p]             = 1'b1;
    endtask

    task automatic set_read(input int unsigned p, input logic [AW-1:0] a);
        raddr[p*AW +: AW] = a;
        re[p]             = 1'b1;
    endtask

    initial begin
`ifdef SPATZ_VRF_RR_ARB_EN
        rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        rr_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        rst = 1'b1; waddr = '0; wdata = '0; wbe = '0; we = '0; raddr = '0; re = 3'b111;
        set_write(0, 8'h40, 64'h1, 8'hFF);
        repeat (3) @(negedge clk);
        check_eq("reset_rvalid", 64'(rvalid), 64'h0);
        check_eq("reset_wvalid", 64'(wvalid), 64'h0);
        check_eq("reset_rdata0", rdata[63:0], 64'h0);
        check_eq("reset_rdata1", rdata[127:64], 64'h0);
        check_eq("reset_rdata2", rdata[191:128], 64'h0);
        rst = 1'b0; we = '0; re = '0;

        // bank conflict on bank 0, port 1 alone on bank 1
        set_read(0, 8'd4); set_read(1, 8'd1); set_read(2, 8'd4);
        @(negedge clk);
        check_eq("conflict_first", 64'(rvalid), 64'h3);
        re = 3'b100;
        // independent banks accept both writes at once
        set_write(0, 8'd1, 64'h11, 8'hFF); set_write(1, 8'd3, 64'h33, 8'hFF);
        #1 check_eq("diff_bank_wvalid", 64'(wvalid), 64'h3);
        @(negedge clk);
        check_eq("conflict_second", 64'(rvalid), 64'h4);
        re = '0; we = '0;

        set_write(0, 8'd5, 64'hDEADBEEF_01234567, 8'hFF);
        #1 check_eq("wr5_wvalid", 64'(wvalid), 64'h1);
        @(negedge clk);
        we = '0; set_read(1, 8'd5);
        @(negedge clk);
        check_eq("rd5_rvalid", 64'(rvalid), 64'h2);
        check_eq("rd5_rdata", rdata[127:64], 64'hDEADBEEF_01234567);
        re = '0;
        @(negedge clk);
        check_eq("idle_rvalid", 64'(rvalid), 64'h0);
        check_eq("hold_rdata", rdata[127:64], 64'hDEADBEEF_01234567);

        set_write(0, 8'd8, 64'h0, 8'hFF);
        @(negedge clk);
        set_write(0, 8'd8, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        @(negedge clk);
        we = '0; set_read(0, 8'd8);
        @(negedge clk);
        check_eq("byte_en_rdata", rdata[63:0], 64'h0000_0000_FFFF_FFFF);
        re = '0;

        set_write(0, 8'd12, 64'hAA, 8'hFF);
        @(negedge clk);
        set_write(0, 8'd12, 64'hBB, 8'hFF); set_read(0, 8'd12);
        @(negedge clk);
        check_eq("rw_same_rvalid", 64'(rvalid), 64'h1);
        check_eq("rw_same_readfirst", rdata[63:0], 64'hAA);
        we = '0;
        @(negedge clk);
        check_eq("rw_after_write", rdata[63:0], 64'hBB);
        re = '0;

        // both write ports held on bank 2
        set_write(0, 8'd2, 64'h22, 8'hFF); set_write(1, 8'd6, 64'h66, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            #1 check_eq($sformatf("wr_arb_%0d", i), 64'(wvalid), 64'(rr_exp[i]));
            @(negedge clk);
        end
        we = '0;

        // async reset drops a pending rvalid and blocks a concurrent write
        set_read(0, 8'd12);
        @(negedge clk);
        check_eq("pre_rst_rvalid", 64'(rvalid), 64'h1);
        check_eq("pre_rst_rdata", rdata[63:0], 64'hBB);
        re = '0;
        set_write(0, 8'd12, 64'h55, 8'hFF);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_rvalid", 64'(rvalid), 64'h0);
        check_eq("mid_rst_rdata", rdata[63:0], 64'h0);
        check_eq("mid_rst_wvalid", 64'(wvalid), 64'h0);
        @(negedge clk);
        rst = 1'b0; we = '0;
        set_read(0, 8'd12);
        @(negedge clk);
        check_eq("post_rst_rvalid", 64'(rvalid), 64'h1);
        check_eq("post_rst_rdata", rdata[63:0], 64'hBB);
        re = '0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
